// File: rtl/arb_pkg.sv
// Shared arbiter definitions: requester count, source index width, the transfer
// state enum and a one-hot grant decoder reused by the arbiter team.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int SRC_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic [SRC_W-1:0] idx;
        logic             valid;  // exactly one bit set
        logic             multi;  // two or more bits set
    } onehot_info_t;

    function automatic onehot_info_t onehot_to_idx(input logic [NREQ-1:0] vec);
        onehot_info_t res;
        int           cnt;
        res.idx   = '0;
        res.valid = 1'b0;
        res.multi = 1'b0;
        cnt       = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (vec[i]) begin
                res.idx = SRC_W'(i);
                cnt     = cnt + 1;
            end
        end
        res.valid = (cnt == 1);
        res.multi = (cnt > 1);
        return res;
    endfunction

endpackage

// File: rtl/arb_payload_mux.sv
// Combinational 4:1 payload selector: picks master sel's DW-bit slice of din.
module arb_payload_mux
    import arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [NREQ*DW-1:0] din,
    input  logic [SRC_W-1:0]   sel,
    output logic [DW-1:0]      dout
);

    logic [DW-1:0] slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice[gi] = din[gi*DW +: DW];
        end
    endgenerate

    assign dout = slice[sel];

endmodule

// File: rtl/arb_grant_xfer.sv
// Locks onto the granted master for one burst and steers its beats onto a shared
// valid/ready channel. Optional stall timeout enabled by macro ARB_XFER_TIMEOUT_EN.
module arb_grant_xfer
    import arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    gnt,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    input  logic [NREQ-1:0]    din_last,
    output logic [DW-1:0]      dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [SRC_W-1:0]   dout_src,
    output logic [NREQ-1:0]    ack,
    output logic               done,
    output logic               abort,
    output logic               gnt_err
);

    localparam logic [3:0] LAST_CNT = 4'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             gnt_err_q, gnt_err_d;
    onehot_info_t     gnt_info;
    logic             accept;

`ifdef ARB_XFER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    assign gnt_info   = onehot_to_idx(gnt);
    assign dout_valid = (state_q == XFER) && req[src_q];
    assign accept     = dout_valid && dout_ready;
    assign ack        = accept ? (NREQ'(1) << src_q) : '0;
    assign dout_src   = src_q;
    assign done       = done_q;
    assign abort      = abort_q;
    assign gnt_err    = gnt_err_q;

    arb_payload_mux #(.DW(DW)) u_mux (
        .din  (din),
        .sel  (src_q),
        .dout (dout)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        gnt_err_d  = gnt_err_q;
`ifdef ARB_XFER_TIMEOUT_EN
        stall_d    = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_info.multi) begin
                    gnt_err_d = 1'b1;
                end else if (gnt_info.valid && req[gnt_info.idx]) begin
                    state_d    = XFER;
                    src_d      = gnt_info.idx;
                    beat_cnt_d = '0;
`ifdef ARB_XFER_TIMEOUT_EN
                    stall_d    = '0;
`endif
                end
            end
            XFER: begin
                // gnt is deliberately ignored here: the lock holds until the burst ends
                if (!req[src_q]) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (dout_ready) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
`ifdef ARB_XFER_TIMEOUT_EN
                    stall_d    = '0;
`endif
                    if (din_last[src_q] || (beat_cnt_q == LAST_CNT)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
`ifdef ARB_XFER_TIMEOUT_EN
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            gnt_err_q  <= 1'b0;
`ifdef ARB_XFER_TIMEOUT_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            gnt_err_q  <= gnt_err_d;
`ifdef ARB_XFER_TIMEOUT_EN
            stall_q    <= stall_d;
`endif
        end
    end

endmodule
